enemy_formation_ctrl: RTL

Per-frame controller for the invader grid. It owns the formation origin, the alive mask and the march/descend direction. It drives `enemy_direction_X`, `enemy_direction_Y` and `delete_enemies` into the per-enemy sprite drawers, which sit directly downstream. It also absorbs hit reports from the collision logic and declares wave-cleared or invaded.

---
 rtl/enemy_formation_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_formation_ctrl.sv
// -----------------------------------------------------------------------------
// enemy_formation_ctrl
// Per-frame controller for the invader grid. Owns the formation origin, the
// alive mask and the march/descend direction, absorbs kill reports from the
// collision logic and declares wave-cleared or invaded.
//
// Optional feature macro: ENEMY_SPEEDUP_EN
//   defined   : horizontal step doubles once a quarter or fewer enemies remain
//   undefined : horizontal step is always STEP_X
//
// Ports
//   frame_clk          frame-rate clock, all logic on posedge
//   Reset              synchronous, active-high
//   start              begin a wave (sampled in IDLE, CLEARED, INVADED)
//   is_playing         0 freezes motion and state (hits still land)
//   hit_strobe         one kill report this frame
//   hit_col / hit_row  grid position of the kill
//   form_x / form_y    formation origin (top-left of col 0, row 0)
//   alive              bit r*COLS+c set while that enemy lives
//   alive_count        popcount of alive
//   enemy_direction_X  0 = left, 1 = right
//   enemy_direction_Y  1 during the descend frame
//   delete_enemies     one-frame pulse on wave end
//   wave_cleared       level, all enemies dead
//   invaded            level, formation reached INVADE_Y
// -----------------------------------------------------------------------------
module enemy_formation_ctrl #(
    parameter int unsigned COLS        = 8,
    parameter int unsigned ROWS        = 4,
    parameter int unsigned SPACING_X   = 60,
    parameter int unsigned SPACING_Y   = 60,
    parameter int unsigned ENEMY_W     = 50,
    parameter int unsigned START_X     = 40,
    parameter int unsigned START_Y     = 40,
    parameter int unsigned LEFT_BOUND  = 0,
    parameter int unsigned RIGHT_BOUND = 639,
    parameter int unsigned STEP_X      = 1,
    parameter int unsigned STEP_Y      = 10,
    parameter int unsigned INVADE_Y    = 400
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   start,
    input  logic                   is_playing,
    input  logic                   hit_strobe,
    input  logic [2:0]             hit_col,
    input  logic [1:0]             hit_row,
    output logic [9:0]             form_x,
    output logic [9:0]             form_y,
    output logic [COLS*ROWS-1:0]   alive,
    output logic [5:0]             alive_count,
    output logic                   enemy_direction_X,
    output logic                   enemy_direction_Y,
    output logic                   delete_enemies,
    output logic                   wave_cleared,
    output logic                   invaded
);

    localparam int unsigned N  = COLS * ROWS;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned AW = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARCH,
        S_DESCEND,
        S_CLEARED,
        S_INVADED
    } state_t;

    state_t          state, state_next;
    logic [9:0]      form_x_next, form_y_next;
    logic [N-1:0]    alive_next;
    logic [5:0]      count_next;
    logic            dir_x_next;
    logic            delete_next;
    logic            cleared_next;
    logic            invaded_next;

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;
    logic [CW-1:0]   lcol, rcol;
    logic [RW-1:0]   brow;

    logic [AW-1:0]   left_edge, right_edge, bottom_next, step;

    logic            hit_valid;
    int              hit_idx;
    logic [N-1:0]    hit_mask;

    // Occupied columns/rows and the extreme ones, from the current (pre-hit) mask
    always_comb begin : extents
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                col_any[c] = col_any[c] | alive[r*int'(COLS)+c];
                row_any[r] = row_any[r] | alive[r*int'(COLS)+c];
            end
        end
        lcol = '0;
        rcol = '0;
        brow = '0;
        for (int c = int'(COLS) - 1; c >= 0; c--) begin
            if (col_any[c]) lcol = CW'(c);
        end
        for (int c = 0; c < int'(COLS); c++) begin
            if (col_any[c]) rcol = CW'(c);
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_any[r]) brow = RW'(r);
        end
    end

    // Pixel extents in 11 bits so nothing wraps near the screen edges
    assign left_edge   = AW'(form_x) + AW'(32'(lcol) * SPACING_X);
    assign right_edge  = AW'(form_x) + AW'(32'(rcol) * SPACING_X) + AW'(ENEMY_W - 1);
    // Bottom after this frame's descend, used only in DESCEND
    assign bottom_next = AW'(form_y) + AW'(STEP_Y) + AW'(32'(brow) * SPACING_Y)
                       + AW'(ENEMY_W - 1);

`ifdef ENEMY_SPEEDUP_EN
    localparam int unsigned FAST_THRESH = N / 4;
    // Double pace once few enemies remain; boundary test uses the same step
    assign step = (32'(alive_count) <= FAST_THRESH) ? AW'(2 * STEP_X) : AW'(STEP_X);
`else
    assign step = AW'(STEP_X);
`endif

    // Kill decode: only in-range hits while a wave is in motion
    always_comb begin : hit_decode
        hit_valid = hit_strobe
                 && (32'(hit_col) < COLS)
                 && (32'(hit_row) < ROWS)
                 && ((state == S_MARCH) || (state == S_DESCEND));
        hit_idx   = int'(hit_row) * int'(COLS) + int'(hit_col);
        hit_mask  = '0;
        for (int i = 0; i < int'(N); i++) begin
            hit_mask[i] = hit_valid && (i == hit_idx);
        end
    end

    // Population of the mask that will be registered this edge
    always_comb begin : popcount
        count_next = '0;
        for (int i = 0; i < int'(N); i++) begin
            count_next = count_next + 6'(alive_next[i]);
        end
    end

    // Next-state and registered-output decode
    always_comb begin : fsm_next
        state_next   = state;
        form_x_next  = form_x;
        form_y_next  = form_y;
        dir_x_next   = enemy_direction_X;
        alive_next   = alive & ~hit_mask;
        delete_next  = 1'b0;
        cleared_next = wave_cleared;
        invaded_next = invaded;

        case (state)
            S_IDLE, S_CLEARED, S_INVADED: begin
                if (start) begin
                    state_next   = S_MARCH;
                    form_x_next  = 10'(START_X);
                    form_y_next  = 10'(START_Y);
                    alive_next   = '1;
                    dir_x_next   = 1'b1;
                    cleared_next = 1'b0;
                    invaded_next = 1'b0;
                end
            end

            S_MARCH: begin
                if (is_playing) begin
                    if (alive == '0) begin
                        state_next   = S_CLEARED;
                        delete_next  = 1'b1;
                        cleared_next = 1'b1;
                    end else if (enemy_direction_X) begin
                        if (right_edge + step > AW'(RIGHT_BOUND)) begin
                            state_next = S_DESCEND;
                        end else begin
                            form_x_next = 10'(AW'(form_x) + step);
                        end
                    end else begin
                        if (left_edge < AW'(LEFT_BOUND) + step) begin
                            state_next = S_DESCEND;
                        end else begin
                            form_x_next = 10'(AW'(form_x) - step);
                        end
                    end
                end
            end

            S_DESCEND: begin
                if (is_playing) begin
                    form_y_next = 10'(AW'(form_y) + AW'(STEP_Y));
                    dir_x_next  = ~enemy_direction_X;
                    // A last kill on this edge defers to CLEARED on the next one
                    if ((alive_next != '0) && (bottom_next >= AW'(INVADE_Y))) begin
                        state_next   = S_INVADED;
                        delete_next  = 1'b1;
                        invaded_next = 1'b1;
                    end else begin
                        state_next = S_MARCH;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge frame_clk) begin : regs
        if (Reset) begin
            state             <= S_IDLE;
            form_x            <= 10'(START_X);
            form_y            <= 10'(START_Y);
            alive             <= '0;
            alive_count       <= '0;
            enemy_direction_X <= 1'b1;
            enemy_direction_Y <= 1'b0;
            delete_enemies    <= 1'b0;
            wave_cleared      <= 1'b0;
            invaded           <= 1'b0;
        end else begin
            state             <= state_next;
            form_x            <= form_x_next;
            form_y            <= form_y_next;
            alive             <= alive_next;
            alive_count       <= count_next;
            enemy_direction_X <= dir_x_next;
            enemy_direction_Y <= (state_next == S_DESCEND);
            delete_enemies    <= delete_next;
            wave_cleared      <= cleared_next;
            invaded           <= invaded_next;
        end
    end

endmodule
